obi_axil_bridge: RTL

Converts the CV32E40P OBI data port (req/gnt/rvalid) into single-outstanding AXI-lite master transactions for the SoC data interconnect. It sits between the core's data interface and the data decoder that fans out to memory and the peripheral wrapper. It owns the transaction FSM, write-channel pairing and response return. It also applies a bus-timeout, so that an access to an unmapped or stuck slave returns an error to the core instead of hanging it.

---
 rtl/obi_axil_bridge.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/obi_axil_bridge.sv
// OBI (req/gnt/rvalid) to single-outstanding AXI-lite master bridge with a bus timeout.
// state     | meaning
// S_IDLE    | ready for a grant; late B/R responses are drained and dropped
// S_WR      | AW and W issued independently until both have handshaked
// S_WR_RESP | waiting for the write response
// S_RD_ADDR | AR issued
// S_RD_DATA | waiting for read data
module obi_axil_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    output logic        m_rready
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Fires in the cycle the counter steps onto TIMEOUT_CYCLES-1, so the error
    // response lands exactly TIMEOUT_CYCLES cycles after the grant.
    localparam int unsigned TO_FIRE = (TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_aw_done;
    logic          r_w_done;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic          w_timeout;
    logic          w_rsp_done;

    assign data_gnt_o = data_req_i & (r_state == S_IDLE) & rst_n;
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_state != S_IDLE) && (r_cnt == CW'(TO_FIRE));
    assign w_rsp_done = ((r_state == S_WR_RESP) && m_bvalid) || ((r_state == S_RD_DATA) && m_rvalid);

    assign m_awaddr = r_addr;
    assign m_araddr = r_addr;
    assign m_wdata  = r_wdata;
    assign m_wstrb  = r_be;

    always_comb begin
        w_state_nxt = r_state;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_arvalid   = 1'b0;
        m_bready    = 1'b0;
        m_rready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                m_bready = 1'b1;
                m_rready = 1'b1;
                if (data_gnt_o) w_state_nxt = data_we_i ? S_WR : S_RD_ADDR;
            end
            S_WR: begin
                m_awvalid = ~r_aw_done & ~w_timeout;
                m_wvalid  = ~r_w_done & ~w_timeout;
                if (w_timeout)
                    w_state_nxt = S_IDLE;
                else if ((r_aw_done | (m_awvalid & m_awready)) && (r_w_done | (m_wvalid & m_wready)))
                    w_state_nxt = S_WR_RESP;
            end
            S_WR_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid || w_timeout) w_state_nxt = S_IDLE;
            end
            S_RD_ADDR: begin
                m_arvalid = ~w_timeout;
                if (w_timeout)
                    w_state_nxt = S_IDLE;
                else if (m_arready)
                    w_state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid || w_timeout) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_be          <= '0;
            data_rvalid_o <= 1'b0;
            data_err_o    <= 1'b0;
            data_rdata_o  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_aw_done <= (r_state == S_WR) && !w_timeout && (r_aw_done | (m_awvalid & m_awready));
            r_w_done  <= (r_state == S_WR) && !w_timeout && (r_w_done | (m_wvalid & m_wready));
            if (data_gnt_o) begin
                r_cnt   <= '0;
                r_addr  <= data_addr_i;
                r_wdata <= data_wdata_i;
                r_be    <= data_be_i;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + CW'(1);
            end
            data_rvalid_o <= w_rsp_done | w_timeout;
            // A response that arrives in the timeout cycle still counts as a success.
            if (w_rsp_done) begin
                data_err_o   <= 1'b0;
                data_rdata_o <= (r_state == S_RD_DATA) ? m_rdata : 32'h0;
            end else if (w_timeout) begin
                data_err_o   <= 1'b1;
                data_rdata_o <= 32'h0;
            end
        end
    end

endmodule
